frame_buffer_scheduler: RTL and testbench
=========================================

# frame_buffer_scheduler

Time-division scheduler that shares the single frame-buffer write port between up to four pixel producers (background, sprites, overlay, debug). Each frame begins with a fixed-length buffer-clear phase, then the block grants the port round-robin in bounded slots, with early release and abort on a new frame. It sits between the producers and the frame-buffer datapath and drives that datapath's clear strobe.

## Interface
- `NUM_REQ`, 4: number of requesters; fixed at 4 for this revision, with a 2-bit grant index.
- `SLOT_LEN`, 8: maximum cycles one grant is held. Legal range is 1..15.
- `FLUSH_LEN`, 8: cycles `buf_clear` is held at frame start. Legal range is 1..15.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse that begins a frame.
- `req` in 4: per-requester access request, level-sensitive.
- `done` in 4: per-requester early release, sampled only for the granted index.
- `grant` out 4: one-hot grant, registered.
- `grant_id` out 2: index of the current or last grant.
- `slot_count` out 4: cycles elapsed in the current slot or flush.
- `buf_clear` out 1: frame-buffer clear strobe.
- `slot_end` out 1: one-cycle pulse in the first cycle after a grant drops.
- `busy` out 1: high in every state except IDLE.

## Operation
- **State machine:** IDLE, FLUSH, ARB, SERVE.
- **Reset:** while `reset` is low, all outputs are forced to 0 and the state is IDLE. The round-robin pointer is set so that req0 is searched first.
- **IDLE:**
  - On `frame_start`, go to FLUSH and clear `slot_count`.
  - Otherwise stay in IDLE.
- **FLUSH:**
  - `buf_clear` is high and `slot_count` increments each cycle.
  - When `slot_count == FLUSH_LEN-1`, go to ARB and clear `slot_count`.
  - The round-robin pointer is reset so that req0 is searched first.
- **ARB:**
  - Search `req`, starting at the index after the last grant and wrapping modulo 4.
  - If a request is found, load `grant`/`grant_id` and go to SERVE.
  - If `req` is all zero, stay in ARB with `grant` at 0.
- **SERVE:**
  - `grant` is held and `slot_count` increments each cycle.
  - The slot ends when any of these holds: `slot_count == SLOT_LEN-1`, `done[grant_id]` is high, or `req[grant_id]` is low.
  - At slot end: clear `grant`, set `slot_end` high for the next cycle, advance the pointer past `grant_id`, clear `slot_count`, and go to ARB.
- **Simultaneous events:** `frame_start` in FLUSH, ARB or SERVE has priority over every other condition.
  - It clears `grant` and restarts FLUSH with `slot_count = 0`.
  - An aborted SERVE still pulses `slot_end`.
- **Non-granted inputs:** `done` bits of non-granted requesters are ignored. A requester that drops `req` outside SERVE simply loses eligibility.
- **Width rules:** `slot_count` is 4 bits and never exceeds `max(SLOT_LEN, FLUSH_LEN) - 1`. Pointer arithmetic is 2-bit modulo.

## Timing
- `req` sampled in ARB at cycle t gives `grant` high at t+1.
- A full slot holds `grant` high for exactly `SLOT_LEN` cycles.
- A `done` pulse sampled at cycle t drops `grant` at t+1.
- Back-to-back grants are separated by exactly one ARB cycle with `grant = 0`.
- `buf_clear` is high for exactly `FLUSH_LEN` cycles, starting the cycle after `frame_start`.
- The first possible grant comes `FLUSH_LEN + 2` cycles after `frame_start`.
- `frame_start` at cycle t gives `grant = 0` and `buf_clear = 1` at t+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **`FB_SCHED_FIXED_PRIORITY_EN` defined:** ARB always searches from req0 upward (req0 highest) and the pointer logic is removed.
- **`FB_SCHED_FIXED_PRIORITY_EN` undefined (default):** round-robin as described in Operation.

## Structure
- **Package `fb_sched_pkg`:**
  - State encoding localparams (IDLE=0, FLUSH=1, ARB=2, SERVE=3).
  - `CNT_W = 4`, `ID_W = 2`.
  - The round-robin search function (next requester from pointer and `req`).
- **Sub-module `frame_buffer_slot_counter`:**
  - 4-bit counter with synchronous clear and enable.
  - Compares against a runtime limit (`SLOT_LEN-1` or `FLUSH_LEN-1`, selected by state) and outputs a `last` flag.

## Test plan
- **Reset and flush:** release `reset`, pulse `frame_start` -> `buf_clear` is high for exactly 8 cycles, `busy` = 1, `grant` = 0 throughout.
- **Full slots, round robin:** hold `req = 4'b1111` after the flush -> grants 0001, 0010, 0100, 1000, 0001, each 8 cycles, with a 1-cycle gap and a `slot_end` pulse at each drop.
- **Early release:** `req = 4'b0100`, assert `done[2]` in the 3rd grant cycle -> `grant` drops on the next cycle, `slot_end` = 1, `slot_count` returns to 0.
- **Ignored done:** pulse `done[0]` while req2 is granted -> no effect, slot runs the full 8 cycles.
- **Abort:** `frame_start` in the 5th SERVE cycle of req1 -> `grant` = 0 and `buf_clear` = 1 on the next cycle, `slot_end` pulses, and the next grant goes to req0 after the flush.
- **Reset mid-operation:** assert `reset` low mid-SERVE -> all outputs 0 immediately (asynchronous), state is IDLE after release. With `FB_SCHED_FIXED_PRIORITY_EN` and `req = 4'b1001`, req0 wins every ARB cycle.

Source files
------------

// File: rtl/fb_sched_pkg.sv
// rtl/fb_sched_pkg.sv - shared types and round-robin search for the frame buffer scheduler
//
// Purpose: state encoding, counter/index widths and the requester search
// function used by frame_buffer_scheduler and frame_buffer_slot_counter.
// Ports: none (package).
package fb_sched_pkg;

   localparam int CNT_W = 4;
   localparam int ID_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_ARB   = 2'd2,
      ST_SERVE = 2'd3
   } state_e;

   typedef struct packed {
      logic            found;
      logic [ID_W-1:0] idx;
   } pick_t;

   // Returns the first requester at or after ptr, wrapping modulo 4.
   // Iterating from the farthest offset down lets the nearest hit win.
   function automatic pick_t rr_search(input logic [ID_W-1:0] ptr, input logic [3:0] req);
      pick_t           pick;
      logic [ID_W-1:0] idx;
      pick = '0;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + ID_W'(i);
         if (req[idx]) begin
            pick.found = 1'b1;
            pick.idx   = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/frame_buffer_slot_counter.sv
// rtl/frame_buffer_slot_counter.sv - slot/flush cycle counter with limit compare
//
// Purpose: 4-bit counter with synchronous clear (priority) and enable; last_o
// flags that the count equals the runtime limit chosen by the scheduler.
// Ports:
//   clk_i, reset_ni   clock, asynchronous active-low reset
//   clr_i, en_i       synchronous clear, count enable
//   limit_i           terminal count for the current phase
//   count_o, last_o   current count, count == limit
module frame_buffer_slot_counter
   import fb_sched_pkg::*;
(
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic [CNT_W-1:0] count_o,
   output logic             last_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = (count_q == limit_i);

endmodule

// File: rtl/frame_buffer_scheduler.sv
// rtl/frame_buffer_scheduler.sv - frame buffer write-port time-division scheduler
//
// Purpose: per frame, holds buf_clear for FLUSH_LEN cycles, then grants the
// write port round-robin to up to four producers in slots of at most
// SLOT_LEN cycles, with early release and abort on a new frame_start.
// Build option: FB_SCHED_FIXED_PRIORITY_EN selects fixed priority (req0
// highest) and removes the round-robin pointer.
// Ports:
//   clk_i, reset_ni     clock, asynchronous active-low reset
//   frame_start_i       one-cycle frame start pulse
//   req_i, done_i       per-requester request level, early release
//   grant_o, grant_id_o one-hot grant, index of current/last grant
//   slot_count_o        cycles elapsed in current slot or flush
//   buf_clear_o         frame buffer clear strobe
//   slot_end_o          pulse in the first cycle after a grant drops
//   busy_o              high outside IDLE
module frame_buffer_scheduler
   import fb_sched_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int SLOT_LEN  = 8,
   parameter int FLUSH_LEN = 8
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               frame_start_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] done_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    grant_id_o,
   output logic [CNT_W-1:0]   slot_count_o,
   output logic               buf_clear_o,
   output logic               slot_end_o,
   output logic               busy_o
);

   localparam logic [CNT_W-1:0] SLOT_LIM  = CNT_W'(SLOT_LEN - 1);
   localparam logic [CNT_W-1:0] FLUSH_LIM = CNT_W'(FLUSH_LEN - 1);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic               slot_end_q, slot_end_d;
   logic               cnt_clr, cnt_en, cnt_last;
   logic [CNT_W-1:0]   cnt_limit;
   logic               slot_done;
   pick_t              pick;

   assign cnt_limit = (state_q == ST_FLUSH) ? FLUSH_LIM : SLOT_LIM;

   frame_buffer_slot_counter u_counter (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .clr_i    (cnt_clr),
      .en_i     (cnt_en),
      .limit_i  (cnt_limit),
      .count_o  (slot_count_o),
      .last_o   (cnt_last)
   );

   // Only the granted requester's done/req bits can end a slot.
   assign slot_done = cnt_last | done_i[grant_id_q] | ~req_i[grant_id_q];

`ifdef FB_SCHED_FIXED_PRIORITY_EN
   assign pick = rr_search('0, req_i);
`else
   logic [ID_W-1:0] ptr_q, ptr_d;

   assign pick = rr_search(ptr_q, req_i);

   // A new frame (and the whole flush) restarts the search at req0.
   always_comb begin
      ptr_d = ptr_q;
      if (frame_start_i || state_q == ST_FLUSH) begin
         ptr_d = '0;
      end else if (state_q == ST_SERVE && slot_done) begin
         ptr_d = grant_id_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      slot_end_d = 1'b0;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      if (frame_start_i) begin
         // New frame overrides everything; an aborted slot still reports its end.
         state_d    = ST_FLUSH;
         grant_d    = '0;
         cnt_clr    = 1'b1;
         slot_end_d = (state_q == ST_SERVE);
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_clr = 1'b1;
            end
            ST_FLUSH: begin
               if (cnt_last) begin
                  state_d = ST_ARB;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_en = 1'b1;
               end
            end
            ST_ARB: begin
               cnt_clr = 1'b1;
               grant_d = '0;
               if (pick.found) begin
                  state_d    = ST_SERVE;
                  grant_d    = NUM_REQ'(1) << pick.idx;
                  grant_id_d = pick.idx;
               end
            end
            ST_SERVE: begin
               if (slot_done) begin
                  state_d    = ST_ARB;
                  grant_d    = '0;
                  slot_end_d = 1'b1;
                  cnt_clr    = 1'b1;
               end else begin
                  cnt_en = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         slot_end_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         slot_end_q <= slot_end_d;
      end
   end

   assign grant_o     = grant_q;
   assign grant_id_o  = grant_id_q;
   assign slot_end_o  = slot_end_q;
   assign buf_clear_o = (state_q == ST_FLUSH);
   assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// tb/tb_frame_buffer_scheduler.sv - self-checking bench for frame_buffer_scheduler
module tb_frame_buffer_scheduler;

   localparam int SLOT_LEN  = 8;
   localparam int FLUSH_LEN = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       frame_start = 1'b0;
   logic [3:0] req = 4'b0;
   logic [3:0] done = 4'b0;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic [3:0] slot_count;
   logic       buf_clear;
   logic       slot_end;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   frame_buffer_scheduler #(
      .NUM_REQ   (4),
      .SLOT_LEN  (SLOT_LEN),
      .FLUSH_LEN (FLUSH_LEN)
   ) dut (
      .clk_i         (clk),
      .reset_ni      (reset_n),
      .frame_start_i (frame_start),
      .req_i         (req),
      .done_i        (done),
      .grant_o       (grant),
      .grant_id_o    (grant_id),
      .slot_count_o  (slot_count),
      .buf_clear_o   (buf_clear),
      .slot_end_o    (slot_end),
      .busy_o        (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: remaining clear cycles, current owner and how long it has held
   // the port, and where the next search starts.
   int   flush_left, owner, held, first, gid, started, mj;
   logic exp_slot_end;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flush_left = 0; owner = -1; held = 0; first = 0; gid = 0; started = 0;
         exp_slot_end = 1'b0;
      end else begin
         exp_slot_end = 1'b0;
         if (frame_start) begin
            if (owner >= 0) exp_slot_end = 1'b1;
            owner = -1; held = 0; flush_left = FLUSH_LEN; first = 0; started = 1;
         end else if (flush_left > 0) begin
            flush_left--;
         end else if (owner >= 0) begin
            if (done[owner] || !req[owner] || held == SLOT_LEN - 1) begin
               exp_slot_end = 1'b1;
               first = (owner + 1) % 4;
               owner = -1;
               held = 0;
            end else begin
               held++;
            end
         end else if (started != 0) begin
            for (int k = 0; k < 4; k++) begin
               mj = (first + k) % 4;
               if (owner < 0 && req[mj]) begin
                  owner = mj; gid = mj; held = 0;
               end
            end
         end
`ifdef FB_SCHED_FIXED_PRIORITY_EN
         first = 0;
`endif
      end
   end

   logic [3:0] m_grant, m_count;

   always @(negedge clk) begin
      m_grant = (owner >= 0) ? 4'(1 << owner) : 4'd0;
      m_count = (flush_left > 0) ? 4'(FLUSH_LEN - flush_left) : ((owner >= 0) ? 4'(held) : 4'd0);
      chk("grant", grant, m_grant);
      chk("grant_id", grant_id, gid);
      chk("slot_count", slot_count, m_count);
      chk("buf_clear", buf_clear, (flush_left > 0));
      chk("slot_end", slot_end, exp_slot_end);
      chk("busy", busy, (started != 0));
   end

   int         clear_cnt;
   logic [3:0] eg;

   initial begin
      cyc(3);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      reset_n = 1'b1;
      cyc(2);

      // Flush: buf_clear for exactly 8 cycles, first grant 10 cycles after frame_start
      frame_start = 1'b1;
      req = 4'b1111;
      cyc(1);
      frame_start = 1'b0;
      clear_cnt = 0;
      for (int k = 1; k < 10; k++) begin
         if (buf_clear) clear_cnt++;
         chk("flush_busy", busy, 1);
         chk("flush_grant", grant, 0);
         cyc(1);
      end
      chk("flush_len", clear_cnt, 8);
      chk("first_grant", grant, 4'b0001);

      // Full slots round robin with a one-cycle gap
      for (int k = 0; k < 45; k++) begin
         eg = (k % 9 < 8) ? 4'(1 << ((k / 9) % 4)) : 4'd0;
         chk("rr_grant", grant, eg);
         if (k % 9 == 8) chk("rr_slot_end", slot_end, 1);
         cyc(1);
      end
      req = 4'b0000;
      cyc(3);

      // Early release by done[2] in the 3rd grant cycle
      req = 4'b0100;
      cyc(1);
      chk("er_grant", grant, 4'b0100);
      cyc(2);
      done = 4'b0100;
      cyc(1);
      done = 4'b0000;
      chk("er_drop", grant, 0);
      chk("er_slot_end", slot_end, 1);
      chk("er_count", slot_count, 0);

      // done of a non-granted requester is ignored
      cyc(1);
      chk("ig_grant", grant, 4'b0100);
      cyc(1);
      done = 4'b0001;
      cyc(1);
      done = 4'b0000;
      cyc(5);
      chk("ig_last", grant, 4'b0100);
      chk("ig_count", slot_count, 7);
      cyc(1);
      chk("ig_drop", grant, 0);
      chk("ig_slot_end", slot_end, 1);

      // Abort in the 5th SERVE cycle of req1
      req = 4'b0010;
      cyc(1);
      chk("ab_grant", grant, 4'b0010);
      cyc(4);
      chk("ab_count", slot_count, 4);
      frame_start = 1'b1;
      cyc(1);
      frame_start = 1'b0;
      req = 4'b1111;
      chk("ab_grant0", grant, 0);
      chk("ab_clear", buf_clear, 1);
      chk("ab_slot_end", slot_end, 1);
      cyc(9);
      chk("ab_next", grant, 4'b0001);

      // Asynchronous reset mid-SERVE
      cyc(2);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_grant", grant, 0);
      chk("ar_busy", busy, 0);
      chk("ar_count", slot_count, 0);
      chk("ar_id", grant_id, 0);
      chk("ar_clear", buf_clear, 0);
      cyc(2);
      reset_n = 1'b1;
      cyc(1);
      chk("ar_idle", busy, 0);

      // req = 1001: alternates in round robin, req0 always wins in fixed priority
      frame_start = 1'b1;
      req = 4'b1001;
      cyc(1);
      frame_start = 1'b0;
      cyc(9);
      chk("pr_first", grant, 4'b0001);
      cyc(9);
`ifdef FB_SCHED_FIXED_PRIORITY_EN
      chk("pr_second", grant, 4'b0001);
`else
      chk("pr_second", grant, 4'b1000);
`endif
      cyc(9);
      chk("pr_third", grant, 4'b0001);
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
